// File: rtl/buraq_pkg.sv
// buraq_pkg: opcodes, immediate formats and the ID/EX pipeline record shared by the Buraq core
package buraq_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } id_ex_t;
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: ID/EX pipeline register bundle; master is the decode stage, slave is execute
interface id_stage_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  modport master (output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rs1, ex_rs2,
                  ex_opcode, ex_funct3, ex_funct7b5, ex_mem_read, ex_mem_write, ex_reg_write);
  modport slave  (input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_rs1, ex_rs2,
                  ex_opcode, ex_funct3, ex_funct7b5, ex_mem_read, ex_mem_write, ex_reg_write);
endinterface

// File: rtl/imm_gen.sv
// imm_gen: sign-extended RV32I immediate for I/S/B/U/J formats, zero for R-type
module imm_gen
  import buraq_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);
  always_comb
    imm = imm_type == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
          imm_type == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          imm_type == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_type == IMM_U ? {instr[31:12], 12'b0} :
          imm_type == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          32'b0;
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, load-use/WB hazard detection and ID/EX register.
// ID_WB_BYPASS_EN: forward the writeback value into ID/EX instead of stalling on WB-RAW.
module id_stage
  import buraq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        id_stall,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  id_stage_if.master  ex
);
  logic [6:0]  opc;
  logic [4:0]  rd;
  logic        supported, uses_rs1, uses_rs2, load_use, wb_raw, hazard;
  logic [31:0] imm, rs1_val, rs2_val;
  imm_type_e   imm_type;
  id_ex_t      ex_d, ex_q;

  assign opc      = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign supported = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                 OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
  assign uses_rs1 = opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
  assign uses_rs2 = opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};

  always_comb
    imm_type = opc inside {OPC_JALR, OPC_LOAD, OPC_OPIMM} ? IMM_I :
               opc == OPC_STORE                          ? IMM_S :
               opc == OPC_BRANCH                         ? IMM_B :
               opc inside {OPC_LUI, OPC_AUIPC}           ? IMM_U :
               opc == OPC_JAL                            ? IMM_J : IMM_NONE;

  imm_gen u_imm_gen (.instr(if_instr[31:7]), .imm_type(imm_type), .imm(imm));

  assign load_use = if_valid && ex_q.valid && ex_q.mem_read && ex_q.rd != 5'd0 &&
                    ((uses_rs1 && ex_q.rd == rs1_addr) || (uses_rs2 && ex_q.rd == rs2_addr));

`ifdef ID_WB_BYPASS_EN
  assign wb_raw  = 1'b0;
  assign rs1_val = wb_en && wb_rd != 5'd0 && wb_rd == rs1_addr ? wb_data : rs1_data;
  assign rs2_val = wb_en && wb_rd != 5'd0 && wb_rd == rs2_addr ? wb_data : rs2_data;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  // The register file only exposes the written value after the edge, so wait one cycle.
  assign wb_raw  = if_valid && wb_en && wb_rd != 5'd0 &&
                   ((uses_rs1 && wb_rd == rs1_addr) || (uses_rs2 && wb_rd == rs2_addr));
  assign rs1_val = rs1_data;
  assign rs2_val = rs2_data;
`endif

  assign hazard   = load_use || wb_raw;
  assign id_stall = hazard && !flush && !reset;

  always_comb begin
    ex_d = '0;
    if (if_valid && supported && !flush && !hazard) begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = if_pc;
      ex_d.rs1_val   = rs1_val;
      ex_d.rs2_val   = rs2_val;
      ex_d.imm       = imm;
      ex_d.rd        = rd;
      ex_d.rs1       = rs1_addr;
      ex_d.rs2       = rs2_addr;
      ex_d.opcode    = opc;
      ex_d.funct3    = if_instr[14:12];
      ex_d.funct7b5  = if_instr[30];
      ex_d.mem_read  = opc == OPC_LOAD;
      ex_d.mem_write = opc == OPC_STORE;
      ex_d.reg_write = !(opc inside {OPC_BRANCH, OPC_STORE}) && rd != 5'd0;
    end
  end

  always_ff @(posedge clock)
    ex_q <= reset ? '0 : ex_d;

  assign ex.ex_valid     = ex_q.valid;
  assign ex.ex_pc        = ex_q.pc;
  assign ex.ex_rs1_val   = ex_q.rs1_val;
  assign ex.ex_rs2_val   = ex_q.rs2_val;
  assign ex.ex_imm       = ex_q.imm;
  assign ex.ex_rd        = ex_q.rd;
  assign ex.ex_rs1       = ex_q.rs1;
  assign ex.ex_rs2       = ex_q.rs2;
  assign ex.ex_opcode    = ex_q.opcode;
  assign ex.ex_funct3    = ex_q.funct3;
  assign ex.ex_funct7b5  = ex_q.funct7b5;
  assign ex.ex_mem_read  = ex_q.mem_read;
  assign ex.ex_mem_write = ex_q.mem_write;
  assign ex.ex_reg_write = ex_q.reg_write;
endmodule
